// File: rtl/lfsr_frame_unpacker_pkg.sv
// Shared types, frame geometry and the LFSR step used by the frame unpacker.
package lfsr_frame_pkg;

  localparam int NIB_W   = 4;
  localparam int LFSR_W  = 16;
  localparam int ENTRIES = 256;
  localparam int PTR_W   = 8;
  localparam int FRAME_W = NIB_W + LFSR_W;
  localparam int BANK_W  = ENTRIES * NIB_W;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

  // One step of the 16-bit Fibonacci LFSR carried in every frame.
  function automatic logic [LFSR_W-1:0] lfsr16_next(input logic [LFSR_W-1:0] q);
    return {q[14:0], q[15] ^ q[14]};
  endfunction

endpackage

// File: rtl/lfsr16_sync.sv
// Lock tracker for the LFSR field: SEARCH/VERIFY/LOCKED, prediction and error count.
module lfsr16_sync
  import lfsr_frame_pkg::*;
#(
  parameter int LOCK_CNT     = 3,
  parameter int MISS_LIMIT   = 4,
  parameter int GATE_ON_LOCK = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid_i,
  input  logic [LFSR_W-1:0] lfsr_i,
  output sync_state_t       state_o,
  output logic              locked_o,
  output logic [LFSR_W-1:0] exp_o,
  output logic [LFSR_W-1:0] err_cnt_o,
  output logic              wr_qual_o
);

  localparam logic [CNT_W-1:0] LOCK_CNT_C   = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] MISS_LIMIT_C = CNT_W'(MISS_LIMIT);

  sync_state_t       state_q, state_d;
  logic              locked_q, locked_d;
  logic [LFSR_W-1:0] exp_q, exp_d;
  logic [LFSR_W-1:0] err_q, err_d;
  logic [CNT_W-1:0]  match_q, match_d;
  logic [CNT_W-1:0]  miss_q, miss_d;

  // Next-state logic: only a valid frame moves the tracker.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    err_d   = err_q;
    match_d = match_q;
    miss_d  = miss_q;
    if (in_valid_i) begin
      case (state_q)
        SEARCH: begin
          if (lfsr_i != 16'h0000) begin
            exp_d   = lfsr16_next(lfsr_i);
            match_d = 8'd0;
            state_d = VERIFY;
          end else begin
            state_d = SEARCH;
          end
        end
        VERIFY: begin
          if (lfsr_i == exp_q) begin
            match_d = match_q + 8'd1;
            exp_d   = lfsr16_next(exp_q);
            if (match_d == LOCK_CNT_C) begin
              state_d = LOCKED;
              miss_d  = 8'd0;
            end else begin
              state_d = VERIFY;
            end
          end else if (lfsr_i == 16'h0000) begin
            // An all-zero field can never belong to a live sequence.
            state_d = SEARCH;
          end else begin
            exp_d   = lfsr16_next(lfsr_i);
            match_d = 8'd0;
            state_d = VERIFY;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction advances whether or not the frame matched.
          exp_d = lfsr16_next(exp_q);
          if (lfsr_i == exp_q) begin
            miss_d = 8'd0;
          end else begin
            miss_d = miss_q + 8'd1;
            err_d  = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
          end
          if (miss_d == MISS_LIMIT_C) begin
            state_d = SEARCH;
            exp_d   = 16'h0000;
            match_d = 8'd0;
          end else begin
            state_d = LOCKED;
          end
        end
        default: begin
          state_d = SEARCH;
          exp_d   = 16'h0000;
          match_d = 8'd0;
          miss_d  = 8'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    locked_d = (state_d == LOCKED);
  end

  // Tracker state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SEARCH;
      locked_q <= 1'b0;
      exp_q    <= 16'h0000;
      err_q    <= 16'h0000;
      match_q  <= 8'd0;
      miss_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
      exp_q    <= exp_d;
      err_q    <= err_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
    end
  end

  assign state_o   = state_q;
  assign locked_o  = locked_q;
  assign exp_o     = exp_q;
  assign err_cnt_o = err_q;
  // The gate looks at the state before this edge's transition.
  assign wr_qual_o = (GATE_ON_LOCK != 0) ? (state_q == LOCKED) : 1'b1;

endmodule

// File: rtl/lfsr_frame_unpacker.sv
// Frame unpacker top: lock tracker plus the 256 x 4-bit nibble bank.
module lfsr_frame_unpacker
  import lfsr_frame_pkg::*;
#(
  parameter int LOCK_CNT     = 3,
  parameter int MISS_LIMIT   = 4,
  parameter int GATE_ON_LOCK = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [FRAME_W-1:0] in_data,
  input  logic               clear_bank,
  output logic [BANK_W-1:0]  bank,
  output logic [PTR_W-1:0]   wr_ptr,
  output logic               wrap,
  output logic [1:0]         state,
  output logic               locked,
  output logic [LFSR_W-1:0]  exp_q,
  output logic [LFSR_W-1:0]  err_cnt
);

  sync_state_t       state_s;
  logic              wr_qual_s;
  logic              we_s;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              wrap_q, wrap_d;

  lfsr16_sync #(
    .LOCK_CNT    (LOCK_CNT),
    .MISS_LIMIT  (MISS_LIMIT),
    .GATE_ON_LOCK(GATE_ON_LOCK)
  ) u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid_i(in_valid),
    .lfsr_i    (in_data[LFSR_W-1:0]),
    .state_o   (state_s),
    .locked_o  (locked),
    .exp_o     (exp_q),
    .err_cnt_o (err_cnt),
    .wr_qual_o (wr_qual_s)
  );

  assign we_s = in_valid & wr_qual_s;

  // Bank/pointer next state; a clear wins over a same-cycle write.
  always_comb begin
    bank_d = bank_q;
    ptr_d  = ptr_q;
    wrap_d = 1'b0;
    if (clear_bank) begin
      bank_d = '0;
      ptr_d  = 8'd0;
      wrap_d = 1'b0;
    end else if (we_s) begin
      bank_d[{ptr_q, 2'b00} +: NIB_W] = in_data[LFSR_W +: NIB_W];
      ptr_d  = ptr_q + 8'd1;
      wrap_d = (ptr_q == 8'hFF);
    end else begin
      wrap_d = 1'b0;
    end
  end

  // Bank, write pointer and wrap pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q <= '0;
      ptr_q  <= 8'd0;
      wrap_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
      ptr_q  <= ptr_d;
      wrap_q <= wrap_d;
    end
  end

  assign bank   = bank_q;
  assign wr_ptr = ptr_q;
  assign wrap   = wrap_q;
  assign state  = state_s;

endmodule

// File: tb/tb_lfsr_frame_unpacker.sv
// Scoreboard bench for lfsr_frame_unpacker: stimulus queues expectations, a monitor checks them.
module tb_lfsr_frame_unpacker;

  localparam int K_STATE = 0;
  localparam int K_LOCK  = 1;
  localparam int K_EXP   = 2;
  localparam int K_ERR   = 3;
  localparam int K_PTR   = 4;
  localparam int K_WRAP  = 5;
  localparam int K_NIB   = 6;
  localparam int K_BANK0 = 7;

  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic [19:0]   in_data;
  logic          clear_bank;
  logic [1023:0] bank;
  logic [7:0]    wr_ptr;
  logic          wrap;
  logic [1:0]    state;
  logic          locked;
  logic [15:0]   exp_q;
  logic [15:0]   err_cnt;

  exp_t        sb[$];
  int          cyc_cnt = 0;
  int          n_cmp   = 0;
  int          n_fail  = 0;
  logic [15:0] cur;

  lfsr_frame_unpacker dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear_bank(clear_bank),
    .bank      (bank),
    .wr_ptr    (wr_ptr),
    .wrap      (wrap),
    .state     (state),
    .locked    (locked),
    .exp_q     (exp_q),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [15:0] tb_next(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[14]};
  endfunction

  function automatic logic [31:0] actual(input int kind, input int idx);
    case (kind)
      K_STATE: return {30'd0, state};
      K_LOCK:  return {31'd0, locked};
      K_EXP:   return {16'd0, exp_q};
      K_ERR:   return {16'd0, err_cnt};
      K_PTR:   return {24'd0, wr_ptr};
      K_WRAP:  return {31'd0, wrap};
      K_NIB:   return {28'd0, bank[idx*4 +: 4]};
      K_BANK0: return (bank == '0) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Queue an expectation for the state right after the coming rising edge.
  task automatic expect_v(input int kind, input int idx, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc  = cyc_cnt + 1;
    e.kind = kind;
    e.idx  = idx;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic send(input logic v, input logic [3:0] nib, input logic [15:0] d, input logic clr);
    in_valid   = v;
    in_data    = {nib, d};
    clear_bank = clr;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: compare every expectation due for the edge just passed.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc == cyc_cnt) begin
      e = sb.pop_front();
      check(e.name, actual(e.kind, e.idx), e.val);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset_n = 1'b0;
    send(1'b0, 4'h0, 16'h0000, 1'b0);
    tick();
    expect_v(K_STATE, 0, 32'd0, "rst_state");
    expect_v(K_LOCK,  0, 32'd0, "rst_locked");
    expect_v(K_EXP,   0, 32'd0, "rst_exp");
    expect_v(K_ERR,   0, 32'd0, "rst_err");
    expect_v(K_PTR,   0, 32'd0, "rst_ptr");
    expect_v(K_WRAP,  0, 32'd0, "rst_wrap");
    expect_v(K_BANK0, 0, 32'd1, "rst_bank_zero");
    tick();
    reset_n = 1'b1;
    tick();

    // Seed and verify 0x0001 -> 0x0008.
    send(1'b1, 4'h0, 16'h0001, 1'b0);
    expect_v(K_STATE, 0, 32'd1, "t1_verify");
    expect_v(K_EXP,   0, 32'h0002, "t1_seed_exp");
    tick();
    send(1'b1, 4'h0, 16'h0002, 1'b0); tick();
    send(1'b1, 4'h0, 16'h0004, 1'b0);
    expect_v(K_STATE, 0, 32'd1, "t1_still_verify");
    tick();
    send(1'b1, 4'h0, 16'h0008, 1'b0);
    expect_v(K_STATE, 0, 32'd2, "t1_locked_state");
    expect_v(K_LOCK,  0, 32'd1, "t1_locked");
    expect_v(K_EXP,   0, 32'h0010, "t1_exp");
    expect_v(K_ERR,   0, 32'd0, "t1_err");
    expect_v(K_PTR,   0, 32'd0, "t1_ptr");
    tick();

    // Locked writes.
    send(1'b1, 4'hA, 16'h0010, 1'b0); tick();
    send(1'b1, 4'h5, 16'h0020, 1'b0);
    expect_v(K_NIB, 0, 32'hA, "t2_nib0");
    expect_v(K_NIB, 1, 32'h5, "t2_nib1");
    expect_v(K_PTR, 0, 32'd2, "t2_ptr");
    expect_v(K_EXP, 0, 32'h0040, "t2_exp");
    tick();
    cur = 16'h0040;
    for (int i = 0; i < 9; i++) begin
      send(1'b1, 4'(i), cur, 1'b0);
      cur = tb_next(cur);
      if (i == 8) expect_v(K_EXP, 0, 32'h8001, "t2_step_4000");
      tick();
    end
    // Idle cycle changes nothing.
    send(1'b0, 4'hF, 16'h0BAD, 1'b0);
    expect_v(K_EXP, 0, 32'h8001, "idle_exp");
    expect_v(K_PTR, 0, 32'd11, "idle_ptr");
    tick();

    // Two misses then a match: stays locked.
    for (int i = 0; i < 2; i++) begin
      send(1'b1, 4'h1, cur ^ 16'h0100, 1'b0);
      cur = tb_next(cur);
      tick();
    end
    send(1'b1, 4'h1, cur, 1'b0);
    cur = tb_next(cur);
    expect_v(K_ERR,   0, 32'd2, "t3_err2");
    expect_v(K_STATE, 0, 32'd2, "t3_still_locked");
    tick();
    // Four consecutive misses drop lock.
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 4'h2, cur ^ 16'h0100, 1'b0);
      cur = tb_next(cur);
      if (i == 2) begin
        expect_v(K_STATE, 0, 32'd2, "t3_locked_after3");
        expect_v(K_ERR,   0, 32'd5, "t3_err5");
      end
      if (i == 3) begin
        expect_v(K_STATE, 0, 32'd0, "t3_search");
        expect_v(K_LOCK,  0, 32'd0, "t3_unlocked");
        expect_v(K_ERR,   0, 32'd6, "t3_err6");
        expect_v(K_EXP,   0, 32'd0, "t3_exp_cleared");
        expect_v(K_PTR,   0, 32'd18, "t3_ptr");
      end
      tick();
    end

    // Zero field in SEARCH and VERIFY; reseed path.
    send(1'b1, 4'hF, 16'h0000, 1'b0);
    expect_v(K_STATE, 0, 32'd0, "t4_zero_search");
    expect_v(K_PTR,   0, 32'd18, "t4_no_write");
    tick();
    send(1'b1, 4'hF, 16'h1234, 1'b0);
    expect_v(K_STATE, 0, 32'd1, "t4_seed");
    expect_v(K_EXP,   0, 32'h2468, "t4_seed_exp");
    tick();
    send(1'b1, 4'hF, 16'h0000, 1'b0);
    expect_v(K_STATE, 0, 32'd0, "t4_zero_verify");
    tick();

    // Clear with no frame, then relock on a fresh sequence.
    send(1'b0, 4'h0, 16'h0000, 1'b1);
    expect_v(K_PTR,   0, 32'd0, "t5_clr_ptr");
    expect_v(K_BANK0, 0, 32'd1, "t5_clr_bank");
    tick();
    cur = 16'hACE1;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 4'h3, cur, 1'b0);
      cur = tb_next(cur);
      tick();
    end
    send(1'b0, 4'h0, 16'h0000, 1'b0);
    expect_v(K_STATE, 0, 32'd2, "t5_relocked");
    expect_v(K_EXP,   0, {16'd0, cur}, "t5_exp");
    expect_v(K_PTR,   0, 32'd0, "t5_ptr0");
    tick();
    for (int i = 0; i < 256; i++) begin
      send(1'b1, 4'(i), cur, 1'b0);
      cur = tb_next(cur);
      if (i < 255) begin
        expect_v(K_WRAP, 0, 32'd0, "t5_no_wrap");
      end else begin
        expect_v(K_WRAP, 0, 32'd1, "t5_wrap");
        expect_v(K_PTR,  0, 32'd0, "t5_ptr_wrapped");
      end
      tick();
    end
    send(1'b1, 4'h7, cur, 1'b0);
    cur = tb_next(cur);
    expect_v(K_WRAP, 0,   32'd0, "t5_wrap_once");
    expect_v(K_PTR,  0,   32'd1, "t5_ptr1");
    expect_v(K_NIB,  0,   32'h7, "t5_nib0_over");
    expect_v(K_NIB,  1,   32'h1, "t5_nib1");
    expect_v(K_NIB,  16,  32'h0, "t5_nib16");
    expect_v(K_NIB,  100, 32'h4, "t5_nib100");
    expect_v(K_NIB,  255, 32'hF, "t5_nib255");
    tick();
    // Clear together with a valid frame: tracking continues.
    send(1'b1, 4'h9, cur, 1'b1);
    cur = tb_next(cur);
    expect_v(K_BANK0, 0, 32'd1, "t5_clr_bank_frame");
    expect_v(K_PTR,   0, 32'd0, "t5_clr_ptr_frame");
    expect_v(K_EXP,   0, {16'd0, cur}, "t5_clr_exp_adv");
    expect_v(K_STATE, 0, 32'd2, "t5_clr_state");
    expect_v(K_ERR,   0, 32'd6, "t5_clr_err_kept");
    tick();

    // Asynchronous reset in the middle of a locked frame.
    send(1'b1, 4'h3, cur, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_state",  {30'd0, state}, 32'd0);
    check("t6_locked", {31'd0, locked}, 32'd0);
    check("t6_exp",    {16'd0, exp_q}, 32'd0);
    check("t6_err",    {16'd0, err_cnt}, 32'd0);
    check("t6_ptr",    {24'd0, wr_ptr}, 32'd0);
    check("t6_bank",   (bank == '0) ? 32'd1 : 32'd0, 32'd1);
    tick();
    send(1'b0, 4'h0, 16'h0000, 1'b0);
    reset_n = 1'b1;
    tick();
    send(1'b1, 4'h1, 16'h0005, 1'b0);
    expect_v(K_EXP,   0, 32'h000A, "t6_seed_exp");
    tick();
    send(1'b1, 4'h1, 16'h0100, 1'b0);
    expect_v(K_STATE, 0, 32'd1, "t6_reseed_state");
    expect_v(K_EXP,   0, 32'h0200, "t6_reseed_exp");
    tick();
    send(1'b1, 4'h1, 16'h0200, 1'b0); tick();
    send(1'b1, 4'h1, 16'h0400, 1'b0);
    expect_v(K_STATE, 0, 32'd1, "t6_verify_2");
    tick();
    send(1'b1, 4'h1, 16'h0800, 1'b0);
    expect_v(K_STATE, 0, 32'd2, "t6_relock");
    expect_v(K_LOCK,  0, 32'd1, "t6_relock_flag");
    expect_v(K_EXP,   0, 32'h1000, "t6_relock_exp");
    expect_v(K_PTR,   0, 32'd0, "t6_relock_ptr");
    tick();
    send(1'b0, 4'h0, 16'h0000, 1'b0);
    tick();
    tick();
    if (sb.size() != 0) check("sb_drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_frame_unpacker.md
Name: lfsr_frame_unpacker

Overview:
- Receive end of the 20-bit frame stream built by the upstream mux/LFSR packer. Each frame is {nibble[3:0], lfsr[15:0]}.
- Tracks the 16-bit LFSR field and locks to it through a SEARCH/VERIFY/LOCKED state machine.
- Counts sequence errors.
- Writes the nibble field into a 256-entry x 4-bit bank, which is the inverse of the upstream 1024:4 mux. The bank is exposed as a flat 1024-bit bus.

Parameters:
- LOCK_CNT, default 3: consecutive matching frames needed in VERIFY to enter LOCKED.
- MISS_LIMIT, default 4: consecutive mismatches in LOCKED that force a return to SEARCH.
- GATE_ON_LOCK, default 1: 1 = the bank is written only while LOCKED; 0 = every valid frame is written.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  frame qualifier, one frame per cycle when high.
- in_data  in  20  frame; [19:16] = nibble, [15:0] = lfsr value.
- clear_bank  in  1  synchronous clear of the bank and the write pointer.
- bank  out  1024  nibble bank; entry i is at bits [i*4 +: 4].
- wr_ptr  out  8  index of the next bank entry to be written.
- wrap  out  1  one-cycle pulse after entry 255 is written.
- state  out  2  0 = SEARCH, 1 = VERIFY, 2 = LOCKED.
- locked  out  1  high when state == LOCKED.
- exp_q  out  16  predicted lfsr value for the next frame.
- err_cnt  out  16  saturating count of mismatches seen while LOCKED.

Behaviour:
- Reset: asynchronous assert, synchronous deassert handled upstream. Reset value of every output and register is 0, and state = SEARCH.
- LFSR step: next(q) = {q[14:0], q[15]^q[14]}. The value 0x0000 is degenerate and is never accepted as a seed.
- Outputs are registered. Effects of a frame sampled on edge N are visible after edge N, with 1-cycle latency. Cycles with in_valid low change nothing except a clear_bank action.
- Tracking FSM, evaluated only when in_valid is high (d = in_data[15:0]):
  - SEARCH:
    - d != 0: exp_q <= next(d), match_cnt <= 0, go to VERIFY.
    - d == 0: stay in SEARCH.
  - VERIFY:
    - d == exp_q: match_cnt++, exp_q <= next(exp_q). When match_cnt reaches LOCK_CNT, go to LOCKED and clear miss_cnt.
    - d != exp_q and d != 0: reseed with exp_q <= next(d), match_cnt <= 0, stay in VERIFY.
    - d == 0: go to SEARCH.
  - LOCKED (flywheel; exp_q <= next(exp_q) on every frame, regardless of match):
    - Match: miss_cnt <= 0.
    - Mismatch: err_cnt++ (saturates at 0xFFFF) and miss_cnt++.
    - miss_cnt reaching MISS_LIMIT: go to SEARCH, exp_q <= 0.
- Bank write:
  - Write enable = in_valid && (GATE_ON_LOCK ? state == LOCKED : 1). The gate uses state before the transition taken on that same edge.
  - On write: bank[wr_ptr*4 +: 4] <= in_data[19:16] and wr_ptr <= wr_ptr + 1, wrapping 255 -> 0. wrap pulses on the edge that writes entry 255.
  - Other entries hold their value.
- clear_bank:
  - bank <= 0, wr_ptr <= 0, wrap <= 0.
  - Takes priority over a simultaneous write.
  - Does not affect the FSM, exp_q or err_cnt; a frame in the same cycle is still tracked.
- Reset mid-operation drops lock, clears the bank and restarts in SEARCH.

Decomposition:
- Package lfsr_frame_pkg holds:
  - state enum (SEARCH, VERIFY, LOCKED)
  - frame field widths and positions (NIB_W = 4, LFSR_W = 16, ENTRIES = 256)
  - function lfsr16_next()
- Sub-module lfsr16_sync: FSM, exp_q, match/miss counters and err_cnt. It outputs a write-enable qualifier.
- The top level holds the bank, the pointer and the wrap logic.

Test Plan:
1. Reset, then frames with lfsr field 0x0001, 0x0002, 0x0004, 0x0008 (LOCK_CNT = 3) -> after 4th frame: state = LOCKED, locked = 1, exp_q = 0x0010, err_cnt = 0, wr_ptr = 0.
2. Locked, then continue at 0x0010 with nibbles 0xA, 0x5 -> bank[3:0] = 0xA, bank[7:4] = 0x5, wr_ptr = 2. A step from 0x4000 gives exp_q = 0x8001.
3. Locked, then 2 corrupted frames, then correct frames -> err_cnt = 2, state stays LOCKED. Next, 4 consecutive corrupted frames -> state = SEARCH, err_cnt = 6, bank writes stop.
4. Frame with lfsr field 0x0000 in SEARCH -> state stays SEARCH. 0x0000 in VERIFY -> state returns to SEARCH.
5. 256 locked frames -> wrap pulses exactly once on the 256th write, wr_ptr = 0. Then clear_bank asserted together with a valid frame -> bank = 0, wr_ptr = 0, exp_q still advances.
6. reset_n pulsed low asynchronously mid-frame while LOCKED -> all outputs 0 immediately, state = SEARCH; relock requires a fresh seed plus LOCK_CNT matches.
